fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Front-end requester for the 4-wide instruction cache read port.
- Issues 4 consecutive halfword-word addresses per cycle.
- Tracks the cache's fixed 2-cycle read latency and buffers returned bundles in a small FIFO toward decode, using a valid/ready handshake.
- Handles redirects (branch/flush) by squashing in-flight reads and flushing the FIFO.

Parameters:
RESET_PC, 15'h0000, word address [15:1] fetched first after reset
FIFO_DEPTH, 4, bundle FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
fetch_en  input  1  permits issuing new cache reads
redirect_valid  input  1  redirect request, single-cycle pulse
redirect_pc  input  [15:1]  new fetch word address
pc_array  output  4x[15:1]  cache read addresses, element k = pc+k
instructions  input  4x[15:0]  cache read data, valid 2 cycles after the address is presented
bundle_valid  output  1  bundle available to decode
bundle_ready  input  1  decode accepts bundle
bundle_pc  output  [15:1]  word address of bundle_instr[0]
bundle_instr  output  4x[15:0]  instructions of head bundle

Behaviour:
- Reset (async, rst_n low):
  - pc=RESET_PC; in-flight tracker cleared; FIFO empty.
  - bundle_valid=0, bundle_pc=0, bundle_instr all 0.
  - pc_array[k]=RESET_PC+k.
- Address generation:
  - pc_array[k] = pc + k, modulo 2^15 (wrap 7FFF->0000).
  - pc_array is always driven; the cache samples it every cycle.
- Issue condition (cycle c): fetch_en && !redirect_valid && (fifo_count + inflight_count) < FIFO_DEPTH.
  - On issue: pc <= pc+4 (mod 2^15).
  - inflight_count is 0..2.
  - The credit rule guarantees the FIFO never overflows and returned data is never dropped.
- Tracker: 2-stage shift register of {valid, pc[15:1]} advanced every cycle.
  - Stage0 loads {issue, pc} at the end of c.
  - Stage1 holds it during c+2, when instructions carries that data.
- Return: if stage1.valid in cycle c+2, push {stage1.pc, instructions} into the FIFO at the end of c+2. bundle_valid can rise in c+3.
- Output handshake:
  - Pop on bundle_valid && bundle_ready.
  - bundle_* reflect the FIFO head and are held stable while valid && !ready.
  - Simultaneous push and pop is allowed at any occupancy, including full (credit ensures pop-then-push is not needed).
- Redirect (cycle r):
  - pc <= redirect_pc; both tracker valid bits cleared; FIFO flushed, so bundle_valid=0 in r+1.
  - No issue in r. First issue of redirect_pc in r+1 (if fetch_en); its bundle is visible at r+4.
  - A handshake in cycle r still counts as consumed; the flush takes priority over a push in r.
  - Back-to-back redirects: the last one wins.
- fetch_en low: issue stops; in-flight reads still complete and push.
- Reset mid-operation: all state is returned to reset values immediately; in-flight data is discarded.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the FIFO is empty (or is emptying via pop this cycle with no other entries) and stage1.valid, the returned bundle is presented combinationally in c+2 (bundle_valid=1). If accepted, it is not written to the FIFO; otherwise it is pushed. Redirect in the same cycle suppresses the bypass.
- Undefined: all returns go through the FIFO; minimum issue-to-bundle latency is 3 cycles.

Test Plan:
- Reset release, RESET_PC=0, fetch_en=1, bundle_ready=1, cache preloaded with data[i]=i:
  - pc_array=0,1,2,3 in cycle 0.
  - First bundle in cycle 3 (cycle 2 with FETCH_BYPASS_EN): bundle_pc=0, instr={0,1,2,3}.
  - Next bundle_pc=4, then 8, one per cycle.
- bundle_ready=0 sustained:
  - Exactly FIFO_DEPTH=4 bundles buffered (pc 0,4,8,C); issue halts.
  - Raising ready drains them in order with no loss or duplication, then resumes at pc 0x10.
- Redirect to 0x100 while 2 reads are in flight and the FIFO holds 2 entries:
  - bundle_valid=0 next cycle.
  - No stale bundles appear.
  - Next bundle_pc=0x100 at r+4.
- Wrap: RESET_PC=0x7FFE:
  - pc_array=7FFE,7FFF,0000,0001.
  - Next issue pc=0x0002.
- fetch_en dropped after 1 issue: exactly 1 bundle delivered, none further; pc holds at 4.
- Assert rst_n low mid-stream with 2 in flight:
  - Outputs zero immediately.
  - After release, the stream restarts from RESET_PC with no stale data.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues 4-wide cache reads, tracks the 2-cycle read latency and
// buffers returned bundles toward decode. Optional macro FETCH_BYPASS_EN adds a FIFO bypass.
module fetch_unit #(
  parameter logic [15:1] RESET_PC   = 15'h0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [15:1]       redirect_pc,
  output logic [3:0][15:1]  pc_array,
  input  logic [3:0][15:0]  instructions,
  output logic              bundle_valid,
  input  logic              bundle_ready,
  output logic [15:1]       bundle_pc,
  output logic [3:0][15:0]  bundle_instr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  logic [15:1]      r_pc;
  logic             r_s0_vld;
  logic [15:1]      r_s0_pc;
  logic             r_s1_vld;
  logic [15:1]      r_s1_pc;
  logic [15:1]      r_mem_pc    [FIFO_DEPTH];
  logic [3:0][15:0] r_mem_instr [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic [1:0]       w_inflight;
  logic [CW:0]      w_occ;
  logic             w_issue;
  logic             w_fifo_vld;
  logic             w_byp;
  logic             w_push;
  logic             w_pop;

  // Credit check counts both buffered bundles and reads still in flight, so returns never overflow
  assign w_inflight = {1'b0, r_s0_vld} + {1'b0, r_s1_vld};
  assign w_occ      = {1'b0, r_count} + {{(CW-1){1'b0}}, w_inflight};
  assign w_issue    = fetch_en && !redirect_valid && (w_occ < DEPTH_C);
  assign w_fifo_vld = (r_count != {CW{1'b0}});
  assign w_pop      = w_fifo_vld && bundle_ready;

`ifdef FETCH_BYPASS_EN
  assign w_byp  = (r_count == {CW{1'b0}}) && r_s1_vld && !redirect_valid;
  assign w_push = r_s1_vld && !redirect_valid && !(w_byp && bundle_ready);
`else
  assign w_byp  = 1'b0;
  assign w_push = r_s1_vld && !redirect_valid;
`endif

  // Cache read addresses for the current fetch pc
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      pc_array[k] = r_pc + 15'(k);
    end
  end

  // Decode-side view of the FIFO head (or of the bypassed return)
  always_comb begin
    bundle_valid = 1'b0;
    bundle_pc    = 15'h0000;
    bundle_instr = '0;
    if (w_fifo_vld) begin
      bundle_valid = 1'b1;
      bundle_pc    = r_mem_pc[r_rd_ptr];
      bundle_instr = r_mem_instr[r_rd_ptr];
    end else if (w_byp) begin
      bundle_valid = 1'b1;
      bundle_pc    = r_s1_pc;
      bundle_instr = instructions;
    end else begin
      bundle_valid = 1'b0;
      bundle_pc    = 15'h0000;
      bundle_instr = '0;
    end
  end

  // Fetch pc: redirect overrides sequential advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_issue) begin
      r_pc <= r_pc + 15'd4;
    end else begin
      r_pc <= r_pc;
    end
  end

  // Latency tracker; a redirect kills both stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_vld <= 1'b0;
      r_s0_pc  <= 15'h0000;
      r_s1_vld <= 1'b0;
      r_s1_pc  <= 15'h0000;
    end else begin
      r_s0_vld <= w_issue;
      r_s0_pc  <= r_pc;
      r_s1_vld <= r_s0_vld && !redirect_valid;
      r_s1_pc  <= r_s0_pc;
    end
  end

  // Bundle FIFO; flush on redirect wins over any push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_pc[i]    <= 15'h0000;
        r_mem_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem_pc[r_wr_ptr]    <= r_s1_pc;
        r_mem_instr[r_wr_ptr] <= instructions;
        r_wr_ptr              <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
